rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, setting the instruction ROM depth to 2^ADDR_W words of 16 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port rx_data, input, 8 bits: load-stream byte.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: rx_data holds a byte.
REQ-006 The block SHALL have port rx_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-007 The block SHALL have port pc, input, 16 bits: the CPU program counter.
REQ-008 The block SHALL have port instruction, output, 16 bits: the ROM word at pc, fed to the CPU.
REQ-009 The block SHALL have port cpu_reset, output, 1 bit: active-high reset driven to the CPU.
REQ-010 The block SHALL have ports loading, done and error, outputs, 1 bit each: status flags.

Function
REQ-011 The state machine SHALL have these states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, RUN and ERROR.
REQ-012 A byte SHALL be accepted only on a rising clk edge with rx_valid=1 and rx_ready=1.
REQ-013 Each accepted byte SHALL advance the state by exactly one step.
REQ-014 rx_ready SHALL be 1 in the states LEN_HI through CSUM_LO, and 0 in RUN and ERROR.
REQ-015 The stream format SHALL be: word count N (big-endian, 2 bytes), then N data words (big-endian, 2 bytes each), then, if configured, a 16-bit checksum.
REQ-016 Data word k (k = 0 to N-1) SHALL be written to ROM address k on the edge that accepts its low byte.
REQ-017 The write-address counter SHALL be ADDR_W+1 bits wide and SHALL NOT wrap.
REQ-018 Transitions:
- LEN_LO goes to ERROR if N > 2^ADDR_W.
- Otherwise, LEN_LO goes to DATA_HI if N > 0.
- Otherwise (N = 0), LEN_LO goes to the end-of-stream target.
- DATA_LO goes to the end-of-stream target after word N-1, else back to DATA_HI.
REQ-019 The end-of-stream target SHALL be CSUM_HI when the checksum is compiled in, else RUN.
REQ-020 Outputs SHALL be decoded combinationally from the state register:
- cpu_reset = 0 only in RUN;
- done = 1 only in RUN;
- error = 1 only in ERROR;
- loading = 1 in LEN_HI through CSUM_LO.
REQ-021 The CPU SHALL therefore leave reset in the cycle immediately after the edge that accepts the final byte.
REQ-022 instruction SHALL be a combinational read of ROM[pc[ADDR_W-1:0]] in RUN, ignoring the upper pc bits (address wrap).
REQ-023 instruction SHALL be 16'h0000 in every other state.
REQ-024 ROM words at or above N SHALL be unspecified; the bench SHALL NOT check them.
REQ-025 RUN and ERROR SHALL be terminal; only reset leaves them, and rx_valid is ignored in them.
REQ-026 rx_data SHALL be ignored whenever rx_valid=0; back-to-back bytes on consecutive cycles SHALL be supported.

Reset
REQ-027 On a rising clk edge with reset=0, the block SHALL enter LEN_HI and clear the word counter, the length register and the checksum accumulator.
REQ-028 Reset SHALL take priority over a simultaneous byte acceptance.
REQ-029 After reset: rx_ready=1, loading=1, cpu_reset=1, done=0, error=0, instruction=16'h0000.
REQ-030 ROM contents SHALL NOT be cleared by reset; a reset mid-load restarts the protocol from LEN_HI.

Configuration
REQ-031 With macro ROM_LOADER_CHECKSUM_EN defined, the block SHALL keep a 16-bit modulo-2^16 sum of all N data words.
REQ-032 With the macro defined, it SHALL compare that sum against the big-endian checksum received in CSUM_HI/CSUM_LO: match goes to RUN, mismatch goes to ERROR.
REQ-033 With the macro undefined, the CSUM states, the accumulator and the compare SHALL be absent, and DATA_LO/LEN_LO go directly to RUN.

Verification
REQ-034 Basic load: send bytes 00 02 00 03 E3 08 (plus E3 0B when checksum is enabled), back-to-back -> rx_ready=0, done=1, cpu_reset=0 the cycle after the last byte; pc=0 -> instruction=16'h0003; pc=1 -> instruction=16'hE308; pc=16'h1001 -> instruction=16'hE308.
REQ-035 Backpressure: the same stream with rx_valid toggled 1/0 every cycle and random rx_data while invalid -> identical ROM contents and done timing relative to the last accepted byte.
REQ-036 Oversize: ADDR_W=12, send 10 01 -> error=1, rx_ready=0, cpu_reset=1, instruction=16'h0000 for all later cycles despite rx_valid=1.
REQ-037 Reset mid-load: after bytes 00 02 00, hold reset=0 for one edge, then send the full basic-load stream -> loading=1 and done=0 right after the reset edge, final result as in REQ-034.
REQ-038 Empty image: send 00 00 (plus 00 00 when checksum is enabled) -> done=1 after the last byte, cpu_reset=0.
REQ-039 Checksum (macro defined): the basic load with checksum E3 0C -> error=1, done=0, cpu_reset=1; with E3 0B -> done=1.

Source files
------------

// File: rtl/rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rom_loader                                                 |
// | Description : Loads a 16-bit instruction ROM from a byte stream.         |
// |               Stream: word count N (BE16), N data words (BE16),          |
// |               optional BE16 checksum. Holds the CPU in reset while the   |
// |               image loads, then releases it and serves instructions.     |
// |               Optional checksum: define ROM_LOADER_CHECKSUM_EN.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rom_loader #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_reset,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam int unsigned C_DEPTH    = 1 << ADDR_W;
  localparam logic [16:0] C_DEPTH_17 = 17'(C_DEPTH);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CSUM_HI = 3'd4,
    S_CSUM_LO = 3'd5,
`endif
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // State entered once the last data word (or an empty length) is taken
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t C_EOS = S_CSUM_HI;
`else
  localparam state_t C_EOS = S_RUN;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_hi;        // high byte of the word being assembled
  logic [15:0]       r_len;       // word count N
  logic [ADDR_W:0]   r_cnt;       // write address; one extra bit so it never wraps
  logic [15:0]       r_rom [0:C_DEPTH-1];
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       r_sum;       // running modulo-2^16 sum of data words
`endif

  logic              w_accept;
  logic [15:0]       w_word;
  logic [16:0]       w_cnt_inc;
  logic              w_last;
  logic              w_oversize;
  logic              w_rom_we;
  logic              w_pc_unused;

  assign w_accept    = rx_valid & rx_ready;
  assign w_word      = {r_hi, rx_data};
  assign w_cnt_inc   = 17'(r_cnt) + 17'd1;
  assign w_last      = (w_cnt_inc == {1'b0, r_len});
  assign w_oversize  = ({1'b0, w_word} > C_DEPTH_17);
  assign w_rom_we    = w_accept & (r_state == S_DATA_LO);
  // Upper pc bits are intentionally ignored: fetches alias modulo the ROM depth
  assign w_pc_unused = ^pc;

  assign instruction = (r_state == S_RUN) ? r_rom[pc[ADDR_W-1:0]] : 16'h0000;

  // State register; reset restarts the protocol regardless of a pending byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_LEN_HI;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and status outputs decoded from the current state
  always_comb begin
    w_next    = r_state;
    rx_ready  = 1'b0;
    loading   = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      S_LEN_HI: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) begin
          if (w_oversize)            w_next = S_ERROR;
          else if (w_word != 16'h0)  w_next = S_DATA_HI;
          else                       w_next = C_EOS;
        end
      end
      S_DATA_HI: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) w_next = w_last ? C_EOS : S_DATA_HI;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CSUM_HI: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) w_next = S_CSUM_LO;
      end
      S_CSUM_LO: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) w_next = (w_word == r_sum) ? S_RUN : S_ERROR;
      end
`endif
      S_RUN: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        w_next = S_ERROR;
      end
    endcase
  end

  // Stream datapath: capture high bytes, the length, and advance the write address
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi  <= 8'h00;
      r_len <= 16'h0000;
      r_cnt <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum <= 16'h0000;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_LEN_HI, S_DATA_HI: r_hi <= rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM_HI:           r_hi <= rx_data;
`endif
        S_LEN_LO:            r_len <= w_word;
        S_DATA_LO: begin
          r_cnt <= w_cnt_inc[ADDR_W:0];
`ifdef ROM_LOADER_CHECKSUM_EN
          r_sum <= r_sum + w_word;
`endif
        end
        default: ;
      endcase
    end
  end

  // ROM write port; contents survive reset, but a reset edge blocks the write
  always_ff @(posedge clk) begin
    if (reset && w_rom_we) begin
      r_rom[r_cnt[ADDR_W-1:0]] <= w_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rom_loader                                              |
// | Description : Self-checking bench for rom_loader (table of streams plus  |
// |               hand-written reset-mid-load sequence, ROM scoreboard).     |
// |               Honours ROM_LOADER_CHECKSUM_EN like the design.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rom_loader;

  localparam int ADDR_W = 12;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam int CS = 2;
  localparam int NV = 6;
`else
  localparam int CS = 0;
  localparam int NV = 5;
`endif
  localparam int ST_LOAD = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        rx_ready;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        loading;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .loading     (loading),
    .done        (done),
    .error       (error)
  );

  typedef struct {
    logic [0:9][7:0] b;
    int              nb;
    int              gap;
    int              exp_st;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  vec_t vecs[NV];
  sb_t  sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %h required %h", name, idx, act, exp);
    end
  endtask

  // Status outputs for an expected state, sampled mid-cycle
  task automatic check_state(input int st, input int idx);
    chk("rx_ready",  idx, 16'(rx_ready),  16'(st == ST_LOAD));
    chk("loading",   idx, 16'(loading),   16'(st == ST_LOAD));
    chk("done",      idx, 16'(done),      16'(st == ST_RUN));
    chk("cpu_reset", idx, 16'(cpu_reset), 16'(st != ST_RUN));
    chk("error",     idx, 16'(error),     16'(st == ST_ERR));
    if (st != ST_RUN) chk("instr_zero", idx, instruction, 16'h0000);
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_state(ST_LOAD, idx);
  endtask

  // Expected ROM words for a successful load, queued as the stream is driven
  task automatic push_expect(input vec_t v);
    int n;
    n = {v.b[0], v.b[1]};
    for (int k = 0; k < n; k++) begin
      sb_q.push_back('{pc: 16'(k), instr: {v.b[2+2*k], v.b[3+2*k]}});
      if (k == n - 1)
        sb_q.push_back('{pc: 16'(k) + 16'(1 << ADDR_W), instr: {v.b[2+2*k], v.b[3+2*k]}});
    end
  endtask

  task automatic drain_sb(input int idx);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      pc = e.pc;
      #1;
      chk("rom_read", idx, instruction, e.instr);
    end
  endtask

  // Drive one stream, check timing around the last byte and terminal behaviour
  task automatic run_stream(input vec_t v, input int idx);
    if (v.exp_st == ST_RUN) push_expect(v);
    for (int j = 0; j < v.nb; j++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = v.b[j];
      if (j == v.nb - 1) chk("done_early", idx, 16'(done), 16'h0000);
      @(posedge clk);
      if (v.gap != 0 && j < v.nb - 1) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    rx_valid = (v.exp_st != ST_LOAD);
    rx_data  = 8'($urandom);
    check_state(v.exp_st, idx);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rx_data = 8'($urandom);
    end
    @(negedge clk);
    check_state(v.exp_st, idx);
    rx_valid = 1'b0;
    drain_sb(idx);
  endtask

  initial begin
    vec_t hv;
    vecs[0] = '{b: {8'h00,8'h02,8'h00,8'h03,8'hE3,8'h08,8'hE3,8'h0B,8'h00,8'h00}, nb: 6 + CS, gap: 0, exp_st: ST_RUN};
    vecs[1] = '{b: {8'h00,8'h02,8'h00,8'h03,8'hE3,8'h08,8'hE3,8'h0B,8'h00,8'h00}, nb: 6 + CS, gap: 1, exp_st: ST_RUN};
    vecs[2] = '{b: {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 2 + CS, gap: 0, exp_st: ST_RUN};
    vecs[3] = '{b: {8'h10,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 2,      gap: 0, exp_st: ST_ERR};
    vecs[4] = '{b: {8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 2,      gap: 0, exp_st: ST_LOAD};
`ifdef ROM_LOADER_CHECKSUM_EN
    vecs[5] = '{b: {8'h00,8'h02,8'h00,8'h03,8'hE3,8'h08,8'hE3,8'h0C,8'h00,8'h00}, nb: 8,      gap: 0, exp_st: ST_ERR};
`endif

    for (int i = 0; i < NV; i++) begin
      do_reset(i);
      run_stream(vecs[i], i);
    end

    // Reset mid-load, with a byte offered on the reset edge itself
    do_reset(100);
    hv = '{b: {8'h00,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 3, gap: 0, exp_st: ST_LOAD};
    for (int j = 0; j < hv.nb; j++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = hv.b[j];
      @(posedge clk);
    end
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    chk("midrst_loading", 101, 16'(loading), 16'h0001);
    chk("midrst_done",    101, 16'(done),    16'h0000);
    chk("midrst_ready",   101, 16'(rx_ready), 16'h0001);
    run_stream(vecs[0], 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
